// File: rtl/tfe_seq_pkg.sv
// Shared types and constants for the TensorFlowE job sequencer.
// Optional stall timeout enabled by defining TFE_SEQ_TIMEOUT_EN.
package tfe_seq_pkg;

  localparam int CORE_W    = 8;
  localparam int LEN_W_DEF = 4;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_LOAD,
    S_READ,
    S_ACC,
    S_OUT,
    S_CAPT,
    S_HOLD
  } state_e;

endpackage

// File: rtl/tfe_seq_watchdog.sv
// Stall counter for the job sequencer; expire fires on the
// TIMEOUT_CYC-th consecutive stalled cycle (used with TFE_SEQ_TIMEOUT_EN).
module tfe_seq_watchdog
  import tfe_seq_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic stall,
  output logic expire
);

  localparam int CW = $clog2(TIMEOUT_CYC + 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign expire = stall && (cnt_q == CW'(TIMEOUT_CYC - 1));

  always_comb begin
    cnt_d = '0;
    if (stall && !expire) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/tfe_job_sequencer.sv
// Sequences one dot-product job through the TensorFlowE core.
// Define TFE_SEQ_TIMEOUT_EN to abort jobs that stall too long.
module tfe_job_sequencer
  import tfe_seq_pkg::*;
#(
  parameter int          LEN_W       = LEN_W_DEF,
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic              clk,
  input  logic              rts,
  input  logic              start,
  input  logic [LEN_W-1:0]  vec_len,
  output logic              busy,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CORE_W-1:0] in_data,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [CORE_W-1:0] res_data,
  output logic              done,
  output logic              err,
  output logic [CORE_W-1:0] core_datos_in,
  output logic              core_ena_write,
  output logic              core_ena_read,
  output logic              core_clear,
  output logic              core_enable_accu,
  output logic              core_ena_out,
  input  logic [CORE_W-1:0] core_datos_out
);

  state_e            state_q, state_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [LEN_W:0]    cnt_q, cnt_d;
  logic [CORE_W-1:0] res_data_q, res_data_d;
  logic              abort_q, abort_d;
  logic              busy_q, busy_d;
  logic              in_ready_q, in_ready_d;
  logic              clear_q, clear_d;
  logic              read_q, read_d;
  logic              accu_q, accu_d;
  logic              out_q, out_d;
  logic              rv_q, rv_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic              wd_expire;

`ifdef TFE_SEQ_TIMEOUT_EN
  logic wd_stall;

  assign wd_stall = (state_q == S_LOAD && !in_valid) ||
                    (state_q == S_HOLD && !res_ready);

  tfe_seq_watchdog #(
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_wd (
    .clk   (clk),
    .rst_n (rts),
    .stall (wd_stall),
    .expire(wd_expire)
  );
`else
  assign wd_expire = 1'b0;
`endif

  assign busy             = busy_q;
  assign in_ready         = in_ready_q;
  assign res_valid        = rv_q;
  assign res_data         = res_data_q;
  assign done             = done_q;
  assign err              = err_q;
  assign core_clear       = clear_q;
  assign core_ena_read    = read_q;
  assign core_enable_accu = accu_q;
  assign core_ena_out     = out_q;
  assign core_ena_write   = in_ready_q & in_valid;
  assign core_datos_in    = in_ready_q ? in_data : '0;

  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    cnt_d      = cnt_q;
    res_data_d = res_data_q;
    abort_d    = abort_q;
    done_d     = 1'b0;
    err_d      = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start && vec_len != '0) begin
          len_d   = vec_len;
          cnt_d   = '0;
          abort_d = 1'b0;
          state_d = S_CLEAR;
        end else if (start) begin
          done_d = 1'b1;
          err_d  = 1'b1;
        end
      end
      S_CLEAR: begin
        // A clear reached through abort closes the job instead of loading.
        if (abort_q) begin
          abort_d = 1'b0;
          done_d  = 1'b1;
          err_d   = 1'b1;
          state_d = S_IDLE;
        end else begin
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        if (in_valid) begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_d == {len_q, 1'b0}) begin
            cnt_d   = '0;
            state_d = S_READ;
          end
        end
      end
      S_READ: state_d = S_ACC;
      S_ACC: begin
        cnt_d   = cnt_q + 1'b1;
        state_d = (cnt_d == {1'b0, len_q}) ? S_OUT : S_READ;
      end
      S_OUT: state_d = S_CAPT;
      S_CAPT: begin
        res_data_d = core_datos_out;
        state_d    = S_HOLD;
      end
      S_HOLD: begin
        if (res_ready) begin
          done_d  = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (wd_expire) begin
      abort_d = 1'b1;
      cnt_d   = '0;
      state_d = S_CLEAR;
    end
    busy_d     = (state_d != S_IDLE);
    in_ready_d = (state_d == S_LOAD);
    clear_d    = (state_d == S_CLEAR);
    read_d     = (state_d == S_READ);
    accu_d     = (state_d == S_ACC);
    out_d      = (state_d == S_OUT);
    rv_d       = (state_d == S_HOLD);
  end

  always_ff @(posedge clk or negedge rts) begin
    if (!rts) begin
      state_q    <= S_IDLE;
      len_q      <= '0;
      cnt_q      <= '0;
      res_data_q <= '0;
      abort_q    <= 1'b0;
      busy_q     <= 1'b0;
      in_ready_q <= 1'b0;
      clear_q    <= 1'b0;
      read_q     <= 1'b0;
      accu_q     <= 1'b0;
      out_q      <= 1'b0;
      rv_q       <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      cnt_q      <= cnt_d;
      res_data_q <= res_data_d;
      abort_q    <= abort_d;
      busy_q     <= busy_d;
      in_ready_q <= in_ready_d;
      clear_q    <= clear_d;
      read_q     <= read_d;
      accu_q     <= accu_d;
      out_q      <= out_d;
      rv_q       <= rv_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

endmodule

// File: tb/tb_tfe_job_sequencer.sv
// Self-checking bench for tfe_job_sequencer: stub core, timeline
// reference model and per-cycle output compare.
module tb_tfe_job_sequencer;

  localparam int LW = 4;

  logic       clk = 1'b0;
  logic       rts = 1'b0;
  logic       start = 1'b0;
  logic       in_valid = 1'b0;
  logic       res_ready = 1'b0;
  logic [LW-1:0] vec_len = '0;
  logic [7:0] in_data = '0;

  logic       busy, in_ready, res_valid, done, err;
  logic [7:0] res_data, core_datos_in, core_datos_out;
  logic       core_ena_write, core_ena_read, core_clear;
  logic       core_enable_accu, core_ena_out;

  always #5 clk = ~clk;

  tfe_job_sequencer #(.LEN_W(LW), .TIMEOUT_CYC(255)) dut (
    .clk             (clk),
    .rts             (rts),
    .start           (start),
    .vec_len         (vec_len),
    .busy            (busy),
    .in_valid        (in_valid),
    .in_ready        (in_ready),
    .in_data         (in_data),
    .res_valid       (res_valid),
    .res_ready       (res_ready),
    .res_data        (res_data),
    .done            (done),
    .err             (err),
    .core_datos_in   (core_datos_in),
    .core_ena_write  (core_ena_write),
    .core_ena_read   (core_ena_read),
    .core_clear      (core_clear),
    .core_enable_accu(core_enable_accu),
    .core_ena_out    (core_ena_out),
    .core_datos_out  (core_datos_out)
  );

  // Stub TensorFlowE core following its documented contract.
  logic [7:0] mem [32];
  logic [4:0] wp, rp;
  logic [7:0] prod, acc, dout;
  assign core_datos_out = dout;

  always @(posedge clk or negedge rts) begin
    if (!rts) begin
      wp <= '0; rp <= '0; prod <= '0; acc <= '0; dout <= '0;
    end else begin
      if (core_clear) begin
        wp <= '0; rp <= '0; acc <= '0;
      end
      if (core_ena_write) begin
        mem[wp] <= core_datos_in;
        wp <= wp + 5'd1;
      end
      if (core_ena_read) begin
        prod <= mem[rp] * mem[rp + 5'd1];
        rp <= rp + 5'd2;
      end
      if (core_enable_accu) acc <= acc + prod;
      if (core_ena_out) dout <= acc;
    end
  end

  int n_clr = 0, n_wr = 0, n_rd = 0, n_acc = 0, n_out = 0;
  always @(negedge clk) begin
    if (core_clear)       n_clr++;
    if (core_ena_write)   n_wr++;
    if (core_ena_read)    n_rd++;
    if (core_enable_accu) n_acc++;
    if (core_ena_out)     n_out++;
  end

  int n_vec = 0, n_bad = 0;
  int k = 0;
  logic chk_en = 1'b0;
  logic e_busy, e_rdy, e_wr, e_clr, e_rd, e_acc, e_out, e_rv, e_done, e_err;
  logic [7:0] e_res;
  logic [7:0] strm [32];

  task automatic cmp(input string nm, input logic [15:0] act,
                     input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      cmp("busy", 16'(busy), 16'(e_busy));
      cmp("in_ready", 16'(in_ready), 16'(e_rdy));
      cmp("ena_write", 16'(core_ena_write), 16'(e_wr));
      cmp("clear", 16'(core_clear), 16'(e_clr));
      cmp("ena_read", 16'(core_ena_read), 16'(e_rd));
      cmp("enable_accu", 16'(core_enable_accu), 16'(e_acc));
      cmp("ena_out", 16'(core_ena_out), 16'(e_out));
      cmp("res_valid", 16'(res_valid), 16'(e_rv));
      cmp("done", 16'(done), 16'(e_done));
      cmp("err", 16'(err), 16'(e_err));
      if (e_rv) cmp("res_data", 16'(res_data), 16'(e_res));
      if (e_wr) cmp("datos_in", 16'(core_datos_in), 16'(in_data));
    end
  end

  task automatic set_idle();
    e_busy = 0; e_rdy = 0; e_wr = 0; e_clr = 0; e_rd = 0;
    e_acc = 0; e_out = 0; e_rv = 0; e_done = 0; e_err = 0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    k++;
  endtask

  task automatic idle(input int n);
    start = 0;
    in_valid = 1'b1;
    repeat (n) begin
      step();
      set_idle();
    end
    in_valid = 1'b0;
  endtask

  function automatic int pulses();
    return n_clr + n_wr + n_rd + n_acc + n_out;
  endfunction

  task automatic run_job(input int L, input int st_at, input int st_n,
                         input int hold_n, input bit poke, input int rst_at,
                         output int rv_cyc, output logic [7:0] res0);
    int beats, used, lc;
    logic [7:0] dot;
    dot = 0;
    for (int i = 0; i < L; i++) dot = dot + strm[2*i] * strm[2*i+1];
    rv_cyc = -1;
    res0 = 0;
    k = 0;
    start = 1;
    vec_len = L[LW-1:0];
    in_valid = 1;
    in_data = strm[0];
    step();
    start = 0;
    set_idle();
    if (L == 0) begin
      e_done = 1; e_err = 1;
      return;
    end
    e_busy = 1; e_clr = 1;
    step();
    beats = 0; used = 0; lc = 0;
    while (beats < 2 * L) begin
      set_idle(); e_busy = 1; e_rdy = 1;
      if (beats == st_at && used < st_n) begin
        in_valid = 0;
        used++;
      end else begin
        in_valid = 1;
        in_data = strm[beats];
      end
      e_wr = in_valid;
      if (lc == rst_at) begin
        rts = 0;
        set_idle();
        #1;
        cmp("rst_ctl", {6'd0, busy, in_ready, res_valid, done, err,
                        core_ena_write, core_ena_read, core_clear,
                        core_enable_accu, core_ena_out}, 16'd0);
        cmp("rst_data", {core_datos_in, res_data}, 16'd0);
        step();
        rts = 1;
        return;
      end
      step();
      if (e_wr) beats++;
      lc++;
    end
    in_valid = 0;
    for (int i = 0; i < L; i++) begin
      set_idle(); e_busy = 1; e_rd = 1; step();
      set_idle(); e_busy = 1; e_acc = 1; step();
    end
    set_idle(); e_busy = 1; e_out = 1; step();
    set_idle(); e_busy = 1; step();
    rv_cyc = k;
    set_idle(); e_busy = 1; e_rv = 1; e_res = dot;
    #3 res0 = res_data;
    for (int j = 0; j < hold_n; j++) begin
      res_ready = 0;
      if (poke) begin
        start = 1;
        vec_len = LW'($urandom_range(1, 15));
      end
      step();
    end
    start = 0;
    res_ready = 1;
    step();
    res_ready = 0;
    set_idle();
    e_done = 1;
  endtask

  initial begin
    int rv, p0, w0, r0, a0, L, sn, sa;
    logic [7:0] res0;
    set_idle();
    e_res = 0;
    repeat (2) @(posedge clk);
    #1;
    cmp("reset_ctl", {6'd0, busy, in_ready, res_valid, done, err,
                      core_ena_write, core_ena_read, core_clear,
                      core_enable_accu, core_ena_out}, 16'd0);
    cmp("reset_res", 16'(res_data), 16'd0);
    rts = 1;
    chk_en = 1;
    idle(2);

    p0 = pulses();
    run_job(0, 99, 0, 0, 0, -1, rv, res0);
    idle(3);
    cmp("empty_core", 16'(pulses() - p0), 16'd0);

    strm[0] = 8'd3; strm[1] = 8'd4;
    run_job(1, 99, 0, 0, 0, -1, rv, res0);
    cmp("single_lat", 16'(rv), 16'd8);
    cmp("single_res", 16'(res0), 16'd12);
    idle(2);

    for (int i = 0; i < 32; i++) strm[i] = 8'($urandom);
    w0 = n_wr; r0 = n_rd; a0 = n_acc;
    run_job(3, 3, 5, 0, 0, -1, rv, res0);
    cmp("stall_lat", 16'(rv), 16'd21);
    cmp("stall_wr", 16'(n_wr - w0), 16'd6);
    cmp("stall_rd", 16'(n_rd - r0), 16'd3);
    cmp("stall_acc", 16'(n_acc - a0), 16'd3);
    idle(2);

    run_job(2, 99, 0, 10, 1, -1, rv, res0);
    idle(3);

    run_job(4, 99, 0, 0, 0, 2, rv, res0);
    idle(4);

    run_job(2, 1, 2, 1, 0, -1, rv, res0);
    run_job(1, 99, 0, 0, 0, -1, rv, res0);
    run_job(0, 99, 0, 0, 0, -1, rv, res0);
    idle(2);

    for (int t = 0; t < 25; t++) begin
      for (int i = 0; i < 32; i++) strm[i] = 8'($urandom);
      L  = $urandom_range(0, 15);
      sn = $urandom_range(0, 4);
      sa = $urandom_range(0, 2 * L);
      run_job(L, sa, sn, $urandom_range(0, 4), 1'($urandom), -1, rv, res0);
      if (L != 0) cmp("rand_lat", 16'(rv), 16'(4 * L + 4 + ((sa < 2 * L) ? sn : 0)));
      if ($urandom_range(0, 1) == 0) idle($urandom_range(1, 3));
    end
    idle(3);

    chk_en = 0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/tfe_job_sequencer.md
# tfe_job_sequencer

- Sequences one dot-product job through the `TensorFlowE` core:
  - accepts a job request plus a byte stream of operand pairs;
  - drives the core's `clear`, `Ena_write`, `Ena_read`, `enable_accu` and `Ena_out` controls in order;
  - returns the 8-bit result over a valid/ready handshake.
- Sits between the top-level pin wrapper and the core, replacing direct pin control of the core enables.

## Interface
- `LEN_W`, 4: width of the vector-length field; maximum of 2^LEN_W−1 element pairs.
- `TIMEOUT_CYC`, 255: stall limit in cycles. Used only with `TFE_SEQ_TIMEOUT_EN`.
- `clk` in 1: clock.
- `rts` in 1: reset, asynchronous, active-low.
- `start` in 1: job request; sampled only in IDLE.
- `vec_len` in LEN_W: number of element pairs; sampled with `start`.
- `busy` out 1: high in every state except IDLE.
- `in_valid` in 1 / `in_ready` out 1 / `in_data` in 8: operand stream, ordered A0,B0,A1,B1,…
- `res_valid` out 1 / `res_ready` in 1 / `res_data` out 8: result handshake.
- `done` out 1: one-cycle pulse at job end.
- `err` out 1: qualifies `done`; 1 = aborted or empty job.
- `core_datos_in` out 8, `core_ena_write` out 1, `core_ena_read` out 1, `core_clear` out 1, `core_enable_accu` out 1, `core_ena_out` out 1: core controls.
- `core_datos_out` in 8: core result.

## Operation
- Core contract:
  - `core_clear` zeroes the core's pointers and accumulator.
  - Each `core_ena_write` stores one byte at the next address.
  - `core_ena_read` fetches the next A/B pair.
  - `core_enable_accu` adds the fetched product to the accumulator.
  - `core_ena_out` presents the accumulator on `core_datos_out` one cycle later.
- FSM states: IDLE, CLEAR, LOAD, READ, ACC, OUT, CAPT, HOLD.
- IDLE:
  - `start` with `vec_len` ≠ 0: latch `vec_len`, go to CLEAR.
  - `start` with `vec_len` = 0: pulse `done` and `err` next cycle, stay IDLE, no core activity.
- CLEAR: `core_clear`=1 for one cycle → LOAD.
- LOAD:
  - `in_ready`=1.
  - `core_ena_write` = `in_valid`; `core_datos_in` = `in_data` (combinational).
  - Beat counter counts accepted beats; after 2·len beats → READ.
- READ / ACC:
  - READ asserts `core_ena_read` for one cycle; ACC asserts `core_enable_accu` for one cycle.
  - The pair repeats len times (element counter), then → OUT.
- OUT: `core_ena_out`=1 for one cycle → CAPT.
- CAPT: `res_data` ← `core_datos_out` (registered) → HOLD.
- HOLD:
  - `res_valid`=1 and `res_data` stable until `res_ready`.
  - On handshake: pulse `done` (`err`=0) and go to IDLE.
- `start` outside IDLE is ignored. No queueing.
- Core control outputs are mutually exclusive in every cycle.

## Timing
- Reset (`rts` low, asynchronous):
  - state = IDLE.
  - All outputs 0, including `res_data`, `core_datos_in` path gating and counters.
- Reset mid-job abandons the job without a `done` pulse. The core is reset by the same `rts`.
- Latency with `vec_len`=1 and `in_valid` held high, `start` sampled at cycle 0:
  - CLEAR at cycle 1.
  - LOAD at cycles 2–3.
  - READ at 4, ACC at 5, OUT at 6, CAPT at 7.
  - `res_valid` first high at cycle 8.
- General minimum: `res_valid` at 4·len+4 cycles after `start`. Each LOAD stall cycle adds one.
- `done` is high in the cycle the FSM is back in IDLE. `start` is accepted in that same cycle.
- Counters are LEN_W+1 bits wide, so 2·len never overflows.

## Configuration
- `TFE_SEQ_TIMEOUT_EN` defined:
  - A stall counter runs in LOAD while `in_valid`=0 and in HOLD while `res_ready`=0; any handshake resets it.
  - When it reaches `TIMEOUT_CYC`: pulse `core_clear` for one cycle, then pulse `done` with `err`=1 and return to IDLE. `res_valid` drops.
- `TFE_SEQ_TIMEOUT_EN` undefined: no counter; the block waits indefinitely. `err` is asserted only for `vec_len`=0.

## Structure
- Package `tfe_seq_pkg` holds:
  - the state enum typedef;
  - `CORE_W`=8;
  - the default `LEN_W`.
- Sub-module `tfe_seq_watchdog` (stall counter plus expiry flag) is instantiated only under `TFE_SEQ_TIMEOUT_EN`.

## Test plan
- Empty job: `vec_len`=0 plus `start` → `done`=`err`=1 next cycle; no core control ever high.
- Single pair: `vec_len`=1, stream 3,4 with no stalls, stub core returns 12 → `res_valid` at cycle 8 with `res_data`=12; `done`=1, `err`=0 after `res_ready`.
- Stalled stream: `vec_len`=3 with `in_valid` low for 5 cycles mid-stream → exactly 6 `core_ena_write` pulses, 3 READ/ACC pairs; `res_valid` at cycle 21.
- Back-pressure: hold `res_ready`=0 for 10 cycles → `res_valid` and `res_data` stay stable; `start` during HOLD is ignored.
- Reset mid-LOAD: `rts` low for one cycle → all outputs 0 immediately, IDLE, no `done`.
- Timeout, with `TFE_SEQ_TIMEOUT_EN`: `in_valid`=0 for 255 cycles in LOAD → one `core_clear` pulse, then `done`=`err`=1.
